// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state codes and widths for the alarm controller
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } alarm_state_t;

    // Time is six packed BCD digits: hh:mm:ss
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_TIME_W  = 6 * BCD_DIGIT_W;

    localparam int TIMER_W     = 10;
    localparam int SNZ_W       = 3;

endpackage

// File: rtl/alarm_sec_timer.sv
// rtl/alarm_sec_timer.sv - loadable 10-bit seconds counter, up/down, saturating
module alarm_sec_timer
    import alarm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    input  logic               count_up,
    input  logic [TIMER_W-1:0] limit,
    output logic [TIMER_W-1:0] count
);

    logic [TIMER_W-1:0] count_q, count_d;

    // Load wins over tick; counting up stops at limit, counting down stops at 0
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick) begin
            if (count_up) begin
                if (count_q < limit) count_d = count_q + 1'b1;
            end else begin
                if (count_q != '0) count_d = count_q - 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm clock arm/ring/snooze controller
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZES      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic                  settime,
    input  logic                  arm_key,
    input  logic                  snooze_key,
    input  logic                  stop_key,
    input  logic [BCD_TIME_W-1:0] cur_time,
    input  logic [BCD_TIME_W-1:0] alarm_time,
    output logic [1:0]            state,
    output logic                  armed,
    output logic                  ringing,
    output logic                  buzzer,
    output logic [SNZ_W-1:0]      snoozes_left
);

    localparam logic [TIMER_W-1:0] RING_LIMIT = TIMER_W'(RING_TIMEOUT_SEC);
    localparam logic [TIMER_W-1:0] SNZ_LOAD   = TIMER_W'(SNOOZE_SEC);
    localparam logic [SNZ_W-1:0]   SNZ_MAX    = SNZ_W'(MAX_SNOOZES);

    alarm_state_t       state_q, state_d;
    logic [SNZ_W-1:0]   snoozes_q, snoozes_d;
    logic               buzzer_q, buzzer_d;
    logic               match_q, match_d;
    logic               alarm_event;
    logic               ring_clr, snz_load;
    logic               ring_expire, snz_expire;
    logic [TIMER_W-1:0] ring_cnt, snz_cnt;

    assign match_d     = (cur_time == alarm_time) && !settime;
    assign alarm_event = match_d && !match_q;
    // The tick that brings the ring timer to the limit ends the ring
    assign ring_expire = sec_tick && (ring_cnt >= RING_LIMIT - 1'b1);
    assign snz_expire  = sec_tick && (snz_cnt <= TIMER_W'(1));

    alarm_sec_timer u_ring_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (ring_clr),
        .load_val ('0),
        .tick     (sec_tick && (state_q == ST_RINGING)),
        .count_up (1'b1),
        .limit    (RING_LIMIT),
        .count    (ring_cnt)
    );

    alarm_sec_timer u_snooze_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (snz_load),
        .load_val (SNZ_LOAD),
        .tick     (sec_tick && (state_q == ST_SNOOZE)),
        .count_up (1'b0),
        .limit    ('0),
        .count    (snz_cnt)
    );

    // Next state, snooze budget and buzzer; branch order encodes key priority
    always_comb begin
        state_d   = state_q;
        snoozes_d = snoozes_q;
        buzzer_d  = 1'b0;
        ring_clr  = 1'b0;
        snz_load  = 1'b0;
        case (state_q)
            ST_DISARMED: begin
                if (arm_key) begin
                    state_d   = ST_ARMED;
                    snoozes_d = SNZ_MAX;
                end
            end
            ST_ARMED: begin
                if (arm_key) begin
                    state_d = ST_DISARMED;
                end else if (alarm_event) begin
                    state_d  = ST_RINGING;
                    ring_clr = 1'b1;
                    buzzer_d = 1'b1;
                end
            end
            ST_RINGING: begin
                buzzer_d = sec_tick ? ~buzzer_q : buzzer_q;
                if (arm_key) begin
                    state_d  = ST_DISARMED;
                    buzzer_d = 1'b0;
                end else if (stop_key) begin
                    state_d   = ST_ARMED;
                    snoozes_d = SNZ_MAX;
                    buzzer_d  = 1'b0;
                end else if (snooze_key && (snoozes_q != '0)) begin
                    state_d   = ST_SNOOZE;
                    snoozes_d = snoozes_q - 1'b1;
                    snz_load  = 1'b1;
                    buzzer_d  = 1'b0;
                end else if (ring_expire) begin
                    state_d   = ST_ARMED;
                    snoozes_d = SNZ_MAX;
                    buzzer_d  = 1'b0;
                end
            end
            ST_SNOOZE: begin
                if (arm_key) begin
                    state_d = ST_DISARMED;
                end else if (stop_key) begin
                    state_d   = ST_ARMED;
                    snoozes_d = SNZ_MAX;
                end else if (snz_expire) begin
                    state_d  = ST_RINGING;
                    ring_clr = 1'b1;
                    buzzer_d = 1'b1;
                end
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    // State and match-edge registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_DISARMED;
            snoozes_q <= '0;
            buzzer_q  <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            snoozes_q <= snoozes_d;
            buzzer_q  <= buzzer_d;
            match_q   <= match_d;
        end
    end

    assign state        = state_q;
    assign armed        = (state_q != ST_DISARMED);
    assign ringing      = (state_q == ST_RINGING);
    assign buzzer       = buzzer_q;
    assign snoozes_left = snoozes_q;

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 The block SHALL have parameter SNOOZE_SEC, default 300, meaning snooze duration in seconds (legal range 1..1023).
REQ-002 The block SHALL have parameter RING_TIMEOUT_SEC, default 60, meaning seconds of ringing before auto-silence (legal range 1..1023).
REQ-003 The block SHALL have parameter MAX_SNOOZES, default 3, meaning snoozes allowed per alarm event (legal range 0..7).
REQ-004 Ports SHALL be as follows; all are synchronous to clk except reset:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- sec_tick  in  1  one-cycle pulse, once per second.
- settime  in  1  time-set mode; high suppresses alarm matching.
- arm_key  in  1  one-cycle pulse; arm/disarm toggle.
- snooze_key  in  1  one-cycle pulse; snooze request.
- stop_key  in  1  one-cycle pulse; silence request.
- cur_time  in  24  current time, BCD {hourMSB,hourLSB,minMSB,minLSB,secMSB,secLSB}.
- alarm_time  in  24  alarm time, same BCD packing.
- state  out  2  FSM state code.
- armed  out  1  high in ARMED, RINGING or SNOOZE.
- ringing  out  1  high in RINGING.
- buzzer  out  1  audible drive; toggles once per second while ringing.
- snoozes_left  out  3  remaining snoozes for the current event.

Function
REQ-005 The FSM SHALL have states DISARMED=0, ARMED=1, RINGING=2 and SNOOZE=3; the state output SHALL equal the current code.
REQ-006 match SHALL be (cur_time==alarm_time) AND NOT settime; the match register SHALL sample match every clk, and an alarm event SHALL be match high with the registered value low (rising edge only).
REQ-007 In DISARMED, arm_key SHALL go to ARMED and load snoozes_left=MAX_SNOOZES.
REQ-008 In ARMED, an alarm event SHALL go to RINGING and clear the ring timer; arm_key SHALL go to DISARMED.
REQ-009 In RINGING, the ring timer SHALL increment on each sec_tick.
REQ-010 In RINGING, stop_key SHALL go to ARMED and reload snoozes_left.
REQ-011 In RINGING, snooze_key with snoozes_left>0 SHALL go to SNOOZE, decrement snoozes_left and load the snooze timer with SNOOZE_SEC; with snoozes_left=0, snooze_key SHALL be ignored.
REQ-012 In RINGING, a sec_tick that makes the ring timer reach RING_TIMEOUT_SEC SHALL go to ARMED and reload snoozes_left.
REQ-013 In SNOOZE, each sec_tick SHALL decrement the snooze timer; a tick with timer=1 SHALL go to RINGING and clear the ring timer.
REQ-014 In SNOOZE, stop_key SHALL go to ARMED and reload snoozes_left.
REQ-015 In RINGING or SNOOZE, arm_key SHALL go to DISARMED.
REQ-016 When events coincide in one cycle, priority SHALL be arm_key > stop_key > snooze_key > timer expiry > alarm event.
REQ-017 All state transitions SHALL take effect on the clk edge following the qualifying input, giving 1-cycle latency.
REQ-018 Alarm events in any state other than ARMED SHALL be ignored, and an alarm event SHALL NOT re-fire while match stays high after a stop.
REQ-019 buzzer SHALL be set to 1 on entry to RINGING, SHALL toggle on each sec_tick in RINGING, and SHALL be 0 in all other states.
REQ-020 Timers SHALL be 10-bit unsigned and SHALL neither wrap nor underflow; the snooze timer SHALL saturate at 0 and the ring timer SHALL stop at RING_TIMEOUT_SEC.

Reset
REQ-021 Assertion of reset (low) SHALL asynchronously force state=DISARMED, armed=0, ringing=0, buzzer=0, snoozes_left=0, both timers=0 and the match register=0.
REQ-022 Reset asserted mid-RINGING or mid-SNOOZE SHALL silence the alarm immediately, without waiting for a clk edge.
REQ-023 After reset deassertion, the first clk edge SHALL evaluate inputs normally, and a match already present at that edge SHALL count as an alarm event only if in ARMED.

Structure
REQ-024 The state codes, the BCD packing widths and the timer width (10) SHALL reside in shared package alarm_pkg.
REQ-025 One sub-module, alarm_sec_timer (a loadable 10-bit seconds counter with up/down select, tick enable and saturation), SHALL be instantiated twice, once for the ring timer and once for the snooze timer.

Verification
REQ-026 The bench SHALL check arm_key; cur_time stepped to equal alarm_time=07:30:00 -> RINGING one cycle after the match, buzzer=1, snoozes_left=3.
REQ-027 The bench SHALL check RINGING; snooze_key -> SNOOZE, snoozes_left=2; after 300 sec_ticks -> RINGING on the 300th tick.
REQ-028 The bench SHALL check RINGING with no input -> ARMED on the 60th sec_tick, buzzer=0, and no re-ring while cur_time stays at 07:30:00.
REQ-029 The bench SHALL check three snoozes used; a 4th snooze_key -> stays RINGING with snoozes_left=0; stop_key -> ARMED with snoozes_left=3.
REQ-030 The bench SHALL check stop_key and snooze_key in the same cycle -> ARMED; arm_key plus stop_key in the same cycle -> DISARMED.
REQ-031 The bench SHALL check settime=1 while cur_time equals alarm_time -> no RINGING; reset pulsed low mid-SNOOZE -> all outputs 0 asynchronously.
